sr_latch_driver: RTL
====================

SR_LATCH_DRIVER -- requirements
Module: sr_latch_driver

Interface
REQ-001 SHALL have parameter PULSE_CYC, default 4: cycles S or R is held high per command; legal range 1..255.
REQ-002 SHALL have parameter SETTLE_CYC, default 3: cycles both S and R are low before feedback is sampled; legal range 2..255.
REQ-003 SHALL have port clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid  input  1  command request.
REQ-006 SHALL have port req_set  input  1  command type: 1 = set latch (Q=1), 0 = reset latch (Q=0); sampled on acceptance.
REQ-007 SHALL have port req_ready  output  1  driver idle and able to accept a command.
REQ-008 SHALL have port S  output  1  set drive to the latch, registered.
REQ-009 SHALL have port R  output  1  reset drive to the latch, registered.
REQ-010 SHALL have port Q_fb  input  1  latch Q feedback, asynchronous to clk.
REQ-011 SHALL have port Qn_fb  input  1  latch Qn feedback, asynchronous to clk.
REQ-012 SHALL have port done  output  1  one-cycle completion pulse.
REQ-013 SHALL have port err  output  1  feedback mismatch flag.

Function
REQ-014 SHALL accept a command on a rising edge where req_valid=1 and req_ready=1; the edge defines cycle 0.
REQ-015 SHALL implement FSM states IDLE, PULSE, SETTLE: IDLE -> PULSE on acceptance; PULSE -> SETTLE after PULSE_CYC cycles; SETTLE -> IDLE after SETTLE_CYC cycles.
REQ-016 SHALL drive S=1 (req_set=1) or R=1 (req_set=0) in cycles 1..PULSE_CYC, and S=R=0 in every other cycle.
REQ-017 SHALL never drive S=1 and R=1 in the same cycle, under any input sequence, including reset.
REQ-018 SHALL synchronize Q_fb and Qn_fb through two flip-flop stages each before any use.
REQ-019 SHALL assert done for exactly one cycle at cycle 1+PULSE_CYC+SETTLE_CYC; that cycle is in IDLE.
REQ-020 SHALL drive req_ready=1 in IDLE only, including the done cycle, allowing back-to-back commands with no gap.
REQ-021 SHALL ignore req_valid while req_ready=0; req_set changes during a command have no effect.
REQ-022 SHALL use an 8-bit down-counter for PULSE and SETTLE timing, reloaded on each state entry.

Reset
REQ-023 SHALL, while rst_n=0, immediately force S=0, R=0, done=0, err=0, req_ready=1, FSM=IDLE and synchronizer stages to 0, independent of clk.
REQ-024 SHALL abort an in-flight command on reset, with no done pulse for it.
REQ-025 SHALL accept a new command on the first rising edge after rst_n deasserts.

Configuration
REQ-026 SHALL check feedback when macro SR_LATCH_DRIVER_FB_CHECK_EN is defined.
REQ-027 With the macro defined: at the done cycle, SHALL compare the synchronized feedback with the expected value (Q=1,Qn=0 for set; Q=0,Qn=1 for reset).
REQ-028 With the macro defined: on mismatch, including Q=Qn, SHALL set err=1 with done; err SHALL stay high until the next accepted command clears it.
REQ-029 With the macro undefined: SHALL tie err to 0, SHALL omit the synchronizers, SHALL leave Q_fb and Qn_fb unused, and timing SHALL be unchanged.

Verification
REQ-030 Defaults; set command accepted at cycle 0 with a model NOR latch in the loop -> S=1 cycles 1-4, R=0 throughout, done=1 at cycle 8 only, err=0.
REQ-031 Reset command following in the done cycle (back-to-back) -> accepted at cycle 8, R=1 cycles 9-12, done at cycle 16, err=0.
REQ-032 FB_CHECK_EN defined; Q_fb held at 0 during a set command -> err=1 at cycle 8, err held until next acceptance, then err=0 on the following cycle.
REQ-033 rst_n pulled low at cycle 2 of a set command -> S=0 immediately with no clk edge, no done, req_ready=1; a command at the first edge after release is accepted.
REQ-034 Random req_valid/req_set, 10k cycles, PULSE_CYC=1, SETTLE_CYC=2 -> S&R never both 1, done count equals accept count, done spacing >= 4 cycles.
REQ-035 Macro undefined; Q_fb=Qn_fb=1 forced -> err=0 always; done at cycle 8.

Source files
------------

// File: rtl/sr_latch_driver.sv
// sr_latch_driver: pulses S or R into an external SR latch for PULSE_CYC cycles,
// waits SETTLE_CYC cycles with both drives low, then signals done.
// Optional feedback check is enabled by defining SR_LATCH_DRIVER_FB_CHECK_EN.
module sr_latch_driver #(
    parameter int unsigned PULSE_CYC  = 4,
    parameter int unsigned SETTLE_CYC = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic req_valid,
    input  logic req_set,
    output logic req_ready,
    output logic S,
    output logic R,
    input  logic Q_fb,
    input  logic Qn_fb,
    output logic done,
    output logic err
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] PULSE  = 2'd1;
    localparam logic [1:0] SETTLE = 2'd2;

    localparam logic [7:0] PULSE_LOAD  = 8'(PULSE_CYC);
    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC);

    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       s_q, s_d;
    logic       r_q, r_d;
    logic       done_q, done_d;
    logic       accept;
    logic       cnt_last;

    assign accept   = req_valid && (state_q == IDLE);
    assign cnt_last = (cnt_q == 8'd1);

    // Next-state logic: S and R come from one decision so they can never both be set.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        r_d     = r_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = PULSE;
                    cnt_d   = PULSE_LOAD;
                    s_d     = req_set;
                    r_d     = !req_set;
                end
            end
            PULSE: begin
                if (cnt_last) begin
                    state_d = SETTLE;
                    cnt_d   = SETTLE_LOAD;
                    s_d     = 1'b0;
                    r_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            SETTLE: begin
                if (cnt_last) begin
                    state_d = IDLE;
                    cnt_d   = 8'd0;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
                s_d     = 1'b0;
                r_d     = 1'b0;
            end
        endcase
    end

    // Control state registers; reset aborts any command in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            s_q     <= 1'b0;
            r_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            s_q     <= s_d;
            r_q     <= r_d;
            done_q  <= done_d;
        end
    end

    assign S         = s_q;
    assign R         = r_q;
    assign done      = done_q;
    assign req_ready = (state_q == IDLE);

`ifdef SR_LATCH_DRIVER_FB_CHECK_EN
    logic q_meta, q_sync;
    logic qn_meta, qn_sync;
    logic cmd_set_q;
    logic err_q;
    logic fb_bad;

    // Two-stage synchronizers for the asynchronous latch feedback.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_meta  <= 1'b0;
            q_sync  <= 1'b0;
            qn_meta <= 1'b0;
            qn_sync <= 1'b0;
        end else begin
            q_meta  <= Q_fb;
            q_sync  <= q_meta;
            qn_meta <= Qn_fb;
            qn_sync <= qn_meta;
        end
    end

    // Q==Qn is always a mismatch, whichever command was issued.
    assign fb_bad = cmd_set_q ? !(q_sync && !qn_sync) : !(!q_sync && qn_sync);

    // Sticky error: evaluated alongside done, cleared by the next accepted command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmd_set_q <= 1'b0;
            err_q     <= 1'b0;
        end else if (accept) begin
            cmd_set_q <= req_set;
            err_q     <= 1'b0;
        end else if ((state_q == SETTLE) && cnt_last) begin
            err_q <= fb_bad;
        end
    end

    assign err = err_q;
`else
    logic unused_fb;
    assign unused_fb = Q_fb ^ Qn_fb;
    assign err       = 1'b0;
`endif

endmodule
